bcd_operand_entry: RTL and testbench
====================================

Name: bcd_operand_entry

Overview:
Upstream operand-entry stage for the single-digit BCD adder datapath. Debounces two push-buttons and captures two BCD digits plus a carry-in from the switches over successive presses. Registers and validates the operands, then presents them to the adder stage with a valid flag, a digit-error flag and an entry-phase indicator.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive clk cycles a key level must hold before it is accepted (10 ms at 50 MHz); minimum 2.

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
sw_digit  input  4  switch value offered as the next BCD digit; quasi-static, sampled directly
sw_cin  input  1  switch carry-in, captured with operand B
key_enter_n  input  1  raw enter push-button, active-low, asynchronous, bouncy
key_clear_n  input  1  raw clear push-button, active-low, asynchronous, bouncy
operand_a  output  4  captured first BCD digit
operand_b  output  4  captured second BCD digit
carry_in  output  1  captured carry-in
operands_valid  output  1  high while A, B and carry_in are a complete valid set
digit_error  output  1  high after a rejected entry (digit > 9)
entry_phase  output  2  0 = awaiting A, 1 = awaiting B, 2 = ready; 3 is never driven

Behaviour:
- Reset (rst_n low, asynchronous): operand_a = 0, operand_b = 0, carry_in = 0, operands_valid = 0, digit_error = 0, entry_phase = 0. Both key synchronisers and debounced levels are set to 1 (released); debounce counters are cleared.
- Each key: 2-flop synchroniser, then a debouncer.
  - Debouncer counter increments on every edge where the synced level differs from the debounced level, and clears on any edge where they match.
  - The debounced level flips on the edge where a mismatch has been seen for DEBOUNCE_CYCLES consecutive edges.
  - A registered one-cycle press pulse follows a 1->0 flip of the debounced level. A release (0->1) produces no pulse.
- Latency: with the raw key held low from sampling edge 1, the press pulse is high after edge DEBOUNCE_CYCLES+2. The FSM acts at edge DEBOUNCE_CYCLES+3.
- Glitches: a bounce shorter than DEBOUNCE_CYCLES produces no pulse. Holding a key produces exactly one pulse.
- FSM states: GET_A (phase 0), GET_B (phase 1), READY (phase 2).
  - GET_A, enter press with sw_digit <= 9: operand_a <= sw_digit, digit_error <= 0, go to GET_B.
  - GET_A, enter press with sw_digit > 9: digit_error <= 1, operand_a unchanged, stay in GET_A.
  - GET_B, enter press with sw_digit <= 9: operand_b <= sw_digit, carry_in <= sw_cin, digit_error <= 0, operands_valid <= 1, go to READY.
  - GET_B, enter press with sw_digit > 9: digit_error <= 1, stay in GET_B.
  - READY, enter press: operands_valid <= 0, go to GET_A. Operands are retained and are not recaptured.
  - Any state, clear press: go to GET_A, all operand outputs <= 0, operands_valid <= 0, digit_error <= 0.
  - Simultaneous clear and enter pulses in the same cycle: clear wins and enter is discarded.
- All outputs are registered, with no combinational path from any input.
- operands_valid is high only in READY. operand_a, operand_b and carry_in are stable while operands_valid is high.
- digit_error is sticky until the next accepted digit or a clear.
- rst_n asserted mid-debounce or mid-entry aborts immediately to the reset state. A key still held at rst_n release does not generate a press until it is released and pressed again.

Optional Feature:
BCD_ENTRY_AUTO_RESTART_EN
- Defined: in READY, an enter press behaves exactly as in GET_A, and operands_valid drops on that same edge.
  - sw_digit <= 9: captures sw_digit into operand_a and goes to GET_B.
  - sw_digit > 9: sets digit_error, clears operands_valid, goes to GET_A.
- Undefined: READY behaviour is as listed under Behaviour. The bench covers both builds.

Test Plan:
- DEBOUNCE_CYCLES=4, reset, enter held low: entry_phase 0->1 exactly at edge 7 after the first low sample; one pulse only while held.
- Enter bounce low 3 cycles then high -> no state change; entry_phase stays 0, digit_error stays 0.
- sw_digit=7, press; sw_digit=5, sw_cin=1, press -> operand_a=7, operand_b=5, carry_in=1, operands_valid=1, entry_phase=2.
- GET_A, sw_digit=12, press -> digit_error=1, entry_phase=0. Then sw_digit=3, press -> digit_error=0, operand_a=3, entry_phase=1.
- Clear and enter pressed in the same cycle from GET_B (A=4) -> operand_a=0, operand_b=0, entry_phase=0, operands_valid=0.
- READY, press with sw_digit=9 -> default build: valid=0, phase 0, operand_a unchanged. With BCD_ENTRY_AUTO_RESTART_EN: operand_a=9, phase 1. Assert rst_n low mid-debounce -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/bcd_operand_entry.sv
// bcd_operand_entry
//   Operand-entry front end for the single-digit BCD adder. Two bouncy,
//   active-low push-buttons (enter, clear) are synchronised and debounced.
//   Successive enter presses capture BCD digit A, then digit B plus carry-in,
//   from the switches. Digits above 9 are rejected and flagged.
//
//   Parameter
//     DEBOUNCE_CYCLES  clk edges a key level must hold before it is accepted (>= 2)
//
//   Ports
//     clk, rst_n       rising-edge clock, asynchronous active-low reset
//     sw_digit[3:0]    switch digit, sampled on the edge the FSM acts
//     sw_cin           switch carry-in, captured together with operand B
//     key_enter_n      raw enter button (active-low, asynchronous, bouncy)
//     key_clear_n      raw clear button (active-low, asynchronous, bouncy)
//     operand_a[3:0]   captured first digit
//     operand_b[3:0]   captured second digit
//     carry_in         captured carry-in
//     operands_valid   high only in READY; operands are stable while high
//     digit_error      sticky flag for a rejected digit (> 9)
//     entry_phase[1:0] FSM state: 0 = awaiting A, 1 = awaiting B, 2 = ready
//
//   Build option
//     BCD_ENTRY_AUTO_RESTART_EN  when defined, an enter press in READY starts
//     a new entry immediately, treating sw_digit as the new operand A.
//
//   Key handshake: each debouncer emits a single-cycle registered press
//   pulse; the FSM consumes it on the following edge. There is no back
//   pressure, so a pulse is either acted on in that cycle or discarded
//   (enter is discarded whenever clear pulses in the same cycle).

module bcd_operand_entry_key #(
  parameter int unsigned CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);
  localparam int unsigned CW = (CYCLES > 2) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic          sync1, sync2, level, started, armed;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      level   <= 1'b1;
      cnt     <= '0;
      started <= 1'b0;
      armed   <= 1'b0;
      press   <= 1'b0;
    end else begin
      sync1   <= key_n;
      sync2   <= sync1;
      started <= 1'b1;
      // sync1 holds a real key sample from the second edge after reset on.
      // Only once the key has been seen released may a press be reported,
      // so a key held through reset release stays silent until re-pressed.
      if (started && sync1) armed <= 1'b1;
      press <= 1'b0;
      if (sync2 != level) begin
        if (cnt == LAST) begin
          level <= sync2;
          cnt   <= '0;
          press <= armed & ~sync2;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

module bcd_operand_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw_digit,
  input  logic       sw_cin,
  input  logic       key_enter_n,
  input  logic       key_clear_n,
  output logic [3:0] operand_a,
  output logic [3:0] operand_b,
  output logic       carry_in,
  output logic       operands_valid,
  output logic       digit_error,
  output logic [1:0] entry_phase
);
  typedef enum logic [1:0] {
    GET_A = 2'd0,
    GET_B = 2'd1,
    READY = 2'd2
  } state_t;

  state_t     state, state_next;
  logic [3:0] a_next, b_next;
  logic       cin_next, valid_next, err_next;
  logic       enter_pulse, clear_pulse, digit_ok;

  bcd_operand_entry_key #(.CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_enter_n),
    .press (enter_pulse)
  );

  bcd_operand_entry_key #(.CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_clear_n),
    .press (clear_pulse)
  );

  assign digit_ok    = (sw_digit <= 4'd9);
  assign entry_phase = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= GET_A;
      operand_a      <= 4'd0;
      operand_b      <= 4'd0;
      carry_in       <= 1'b0;
      operands_valid <= 1'b0;
      digit_error    <= 1'b0;
    end else begin
      state          <= state_next;
      operand_a      <= a_next;
      operand_b      <= b_next;
      carry_in       <= cin_next;
      operands_valid <= valid_next;
      digit_error    <= err_next;
    end
  end

  always_comb begin
    state_next = state;
    a_next     = operand_a;
    b_next     = operand_b;
    cin_next   = carry_in;
    valid_next = operands_valid;
    err_next   = digit_error;
    if (clear_pulse) begin
      state_next = GET_A;
      a_next     = 4'd0;
      b_next     = 4'd0;
      cin_next   = 1'b0;
      valid_next = 1'b0;
      err_next   = 1'b0;
    end else if (enter_pulse) begin
      case (state)
        GET_A: begin
          if (digit_ok) begin
            a_next     = sw_digit;
            err_next   = 1'b0;
            state_next = GET_B;
          end else begin
            err_next   = 1'b1;
          end
        end
        GET_B: begin
          if (digit_ok) begin
            b_next     = sw_digit;
            cin_next   = sw_cin;
            err_next   = 1'b0;
            valid_next = 1'b1;
            state_next = READY;
          end else begin
            err_next   = 1'b1;
          end
        end
        READY: begin
          valid_next = 1'b0;
`ifdef BCD_ENTRY_AUTO_RESTART_EN
          if (digit_ok) begin
            a_next     = sw_digit;
            err_next   = 1'b0;
            state_next = GET_B;
          end else begin
            err_next   = 1'b1;
            state_next = GET_A;
          end
`else
          // Operands are kept for inspection; the next press starts over.
          state_next = GET_A;
`endif
        end
        default: begin
          state_next = GET_A;
          valid_next = 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_operand_entry.sv
// tb_bcd_operand_entry
//   Directed bench for bcd_operand_entry with DEBOUNCE_CYCLES = 4. Stimulus
//   pushes the expected output bundle into exp_q before each action; a
//   monitor samples on the falling edge and pops/compares every time the
//   registered outputs change. Bundle layout:
//   {operand_a, operand_b, carry_in, operands_valid, digit_error, entry_phase}.

module tb_bcd_operand_entry;
  localparam int unsigned DB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw_digit = 4'd0;
  logic       sw_cin = 1'b0;
  logic       key_enter_n = 1'b1;
  logic       key_clear_n = 1'b1;
  logic [3:0] operand_a, operand_b;
  logic       carry_in, operands_valid, digit_error;
  logic [1:0] entry_phase;

  bcd_operand_entry #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sw_digit       (sw_digit),
    .sw_cin         (sw_cin),
    .key_enter_n    (key_enter_n),
    .key_clear_n    (key_clear_n),
    .operand_a      (operand_a),
    .operand_b      (operand_b),
    .carry_in       (carry_in),
    .operands_valid (operands_valid),
    .digit_error    (digit_error),
    .entry_phase    (entry_phase)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard
  logic [14:0] exp_q[$];
  int          exp_cyc[$];
  int          total = 0;
  int          bad = 0;
  logic [3:0]  m_a = 4'd0, m_b = 4'd0;
  logic        m_c = 1'b0, m_v = 1'b0, m_e = 1'b0;
  logic [1:0]  m_p = 2'd0;

  function automatic logic [14:0] outs();
    return {operand_a, operand_b, carry_in, operands_valid, digit_error, entry_phase};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic push_exp(input int at_cyc);
    exp_q.push_back({m_a, m_b, m_c, m_v, m_e, m_p});
    exp_cyc.push_back(at_cyc);
  endtask

  task automatic model_zero();
    m_a = 4'd0; m_b = 4'd0; m_c = 1'b0; m_v = 1'b0; m_e = 1'b0; m_p = 2'd0;
  endtask

  // driver tasks (all inputs change on the falling edge)
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_enter(input int hold);
    key_enter_n = 1'b0;
    tick(hold);
    key_enter_n = 1'b1;
    tick(12);
  endtask

  task automatic press_clear();
    key_clear_n = 1'b0;
    tick(10);
    key_clear_n = 1'b1;
    tick(12);
  endtask

  // monitor: every change of the registered outputs consumes one expectation
  initial begin : monitor
    logic [14:0] prev, cur, e;
    int          ec;
    @(posedge rst_n);
    @(negedge clk);
    prev = outs();
    forever begin
      @(negedge clk);
      cur = outs();
      if (cur !== prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_change", {17'd0, cur}, {17'd0, prev});
        end else begin
          e  = exp_q.pop_front();
          ec = exp_cyc.pop_front();
          check("outputs", {17'd0, cur}, {17'd0, e});
          if (ec >= 0) check("change_cycle", cyc, ec);
        end
      end
      prev = cur;
    end
  end

  initial begin : stimulus
    int c0;
    // reset state
    tick(3);
    #1;
    check("reset_outputs", {17'd0, outs()}, 32'd0);
    rst_n = 1'b1;
    tick(6);

    // bounce of 3 low cycles: no pulse
    key_enter_n = 1'b0;
    tick(3);
    key_enter_n = 1'b1;
    tick(15);
    check("bounce_phase", {30'd0, entry_phase}, 32'd0);
    check("bounce_error", {31'd0, digit_error}, 32'd0);

    // latency and single pulse while held (a 2nd pulse would accept B=7)
    sw_digit = 4'd7;
    c0 = cyc;
    m_a = 4'd7; m_p = 2'd1;
    push_exp(c0 + DB + 3);
    press_enter(30);

    // operand B with carry
    sw_digit = 4'd5; sw_cin = 1'b1;
    m_b = 4'd5; m_c = 1'b1; m_v = 1'b1; m_p = 2'd2;
    push_exp(-1);
    press_enter(10);

    // enter in READY with digit 9
    sw_digit = 4'd9; sw_cin = 1'b0;
`ifdef BCD_ENTRY_AUTO_RESTART_EN
    m_a = 4'd9; m_v = 1'b0; m_p = 2'd1;
`else
    m_v = 1'b0; m_p = 2'd0;
`endif
    push_exp(-1);
    press_enter(10);

    // clear back to a known empty GET_A
    model_zero();
    push_exp(-1);
    press_clear();

    // rejected digit in GET_A, then accepted digit clears the flag
    sw_digit = 4'd12;
    m_e = 1'b1;
    push_exp(-1);
    press_enter(10);
    sw_digit = 4'd3;
    m_e = 1'b0; m_a = 4'd3; m_p = 2'd1;
    push_exp(-1);
    press_enter(10);

    // rejected digit in GET_B
    sw_digit = 4'd11;
    m_e = 1'b1;
    push_exp(-1);
    press_enter(10);

    // clear, enter A=4, then clear+enter together from GET_B
    model_zero();
    push_exp(-1);
    press_clear();
    sw_digit = 4'd4;
    m_a = 4'd4; m_p = 2'd1;
    push_exp(-1);
    press_enter(10);
    sw_digit = 4'd8;
    model_zero();
    push_exp(-1);
    key_enter_n = 1'b0;
    key_clear_n = 1'b0;
    tick(10);
    key_enter_n = 1'b1;
    key_clear_n = 1'b1;
    tick(12);

    // A=6, then reset asserted mid-debounce with enter held through release
    sw_digit = 4'd6;
    m_a = 4'd6; m_p = 2'd1;
    push_exp(-1);
    press_enter(10);
    model_zero();
    push_exp(-1);
    key_enter_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset", {17'd0, outs()}, 32'd0);
    tick(3);
    rst_n = 1'b1;
    tick(20);
    key_enter_n = 1'b1;
    tick(12);
    check("held_at_reset_phase", {30'd0, entry_phase}, 32'd0);

    // fresh press after release is accepted
    sw_digit = 4'd2;
    m_a = 4'd2; m_p = 2'd1;
    push_exp(-1);
    press_enter(10);

    tick(5);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
